// File: rtl/led_pkg.sv
// Shared types for the LED array driver: flash sequencer states and per-LED colour width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_pkg;

    // Bits per LED, one per colour channel.
    localparam int LED_RGB_W = 3;

    typedef logic [LED_RGB_W-1:0] led_rgb_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } led_state_e;

endpackage

// File: rtl/led_array_driver_blink_timer.sv
// Prescaler for the blink and flash timing: tick is high on the last cycle of each BLINK_DIV period.
// Latency: tick decodes the registered count; restart clears the count on the next edge.
// Backpressure: none; free-running, restart always wins over wrap.
module blink_timer #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    assign tick = (div_cnt_q == CNT_W'(BLINK_DIV - 1));

    // Next count: restart and terminal count both return to zero.
    always_comb begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
        if (restart || tick) begin
            div_cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/led_array_driver.sv
// Multiplexes guess/history patterns onto NUM_LEDS RGB LEDs with blink and win/lose flash; PWM dimming when LED_PWM_EN is defined.
// Latency: rgb_out, flash_busy and flash_done are registered, one cycle after their inputs; PWM gating adds none.
// Backpressure: none; flash_start while a flash is running is dropped, not queued.
module led_array_driver
    import led_pkg::*;
#(
    parameter  int NUM_LEDS     = 4,
    parameter  int COLOR_W      = LED_RGB_W,
    parameter  int BLINK_DIV    = 25_000_000,
    parameter  int FLASH_CYCLES = 3,
    parameter  int PWM_W        = 4,
    localparam int IDX_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode_guess,
    input  logic [IDX_W-1:0]            blink_idx,
    input  logic [NUM_LEDS*COLOR_W-1:0] guess_rgb,
    input  logic [NUM_LEDS*COLOR_W-1:0] history_rgb,
    input  logic                        flash_start,
    input  logic [COLOR_W-1:0]          flash_rgb,
    input  logic [PWM_W-1:0]            brightness,
    output logic [NUM_LEDS*COLOR_W-1:0] rgb_out,
    output logic                        flash_busy,
    output logic                        flash_done
);

    localparam int RGB_W  = NUM_LEDS * COLOR_W;
    localparam int FCNT_W = $clog2(FLASH_CYCLES + 1);

    led_state_e         state_q, state_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic               phase_q, phase_d;
    logic               mode_prev_q, mode_prev_d;
    logic [IDX_W-1:0]   idx_prev_q, idx_prev_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               restart;
    logic               tick;
    logic               blink_chg;

    blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // Sequencer: blink phase in IDLE, on/off periods while flashing.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        phase_d     = phase_q;
        done_d      = 1'b0;
        restart     = 1'b0;
        mode_prev_d = mode_guess;
        idx_prev_d  = blink_idx;
        blink_chg   = (mode_guess != mode_prev_q) || (blink_idx != idx_prev_q);

        case (state_q)
            IDLE: begin
                if (flash_start) begin
                    // Flash takes priority; a coincident blink change still leaves the LED lit-first.
                    state_d = FLASH_ON;
                    fcnt_d  = '0;
                    restart = 1'b1;
                    if (blink_chg) begin
                        phase_d = 1'b1;
                    end
                end else if (blink_chg) begin
                    // New selection is shown lit for a full half-period first.
                    restart = 1'b1;
                    phase_d = 1'b1;
                end else if (tick) begin
                    phase_d = ~phase_q;
                end
            end
            FLASH_ON: begin
                if (tick) begin
                    state_d = FLASH_OFF;
                end
            end
            FLASH_OFF: begin
                if (tick) begin
                    if (fcnt_q == FCNT_W'(FLASH_CYCLES - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        phase_d = 1'b1;
                        restart = 1'b1;
                    end else begin
                        fcnt_d  = fcnt_q + FCNT_W'(1);
                        state_d = FLASH_ON;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output mux from the next state so rgb_out, busy and done line up on the same cycle.
    always_comb begin
        rgb_d  = '0;
        busy_d = (state_d != IDLE);
        case (state_d)
            IDLE: begin
                if (mode_guess) begin
                    rgb_d = guess_rgb;
                    for (int i = 0; i < NUM_LEDS; i++) begin
                        if (!phase_d && (32'(blink_idx) == i)) begin
                            rgb_d[i*COLOR_W +: COLOR_W] = '0;
                        end
                    end
                end else begin
                    rgb_d = history_rgb;
                end
            end
            FLASH_ON: begin
                rgb_d = {NUM_LEDS{flash_rgb}};
            end
            default: begin
                rgb_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            phase_q     <= 1'b1;
            mode_prev_q <= 1'b0;
            idx_prev_q  <= '0;
            rgb_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            phase_q     <= phase_d;
            mode_prev_q <= mode_prev_d;
            idx_prev_q  <= idx_prev_d;
            rgb_q       <= rgb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign flash_busy = busy_q;
    assign flash_done = done_q;

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic             pwm_on;

    // Free-running duty counter; all-ones brightness forces full on.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        pwm_on    = (pwm_cnt_q < brightness) || (&brightness);
    end

    // Duty counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign rgb_out = rgb_q & {RGB_W{pwm_on}};
`else
    // Brightness has no effect without PWM; outputs are full-on.
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign rgb_out = rgb_q;
`endif

endmodule

// File: tb/tb_led_array_driver.sv
// Directed bench for led_array_driver: reset, blink, blink restart, flash, reset mid-flash, brightness.
// Latency: checks sample on the falling edge, one rising edge after each stimulus change.
// Backpressure: n/a.
module tb_led_array_driver;

    localparam int NUM_LEDS = 4;
    localparam int COLOR_W  = 3;
    localparam int PWM_W    = 4;
    localparam int IDX_W    = 2;

    logic                        clk;
    logic                        rst;
    logic                        mode_guess;
    logic [IDX_W-1:0]            blink_idx;
    logic [NUM_LEDS*COLOR_W-1:0] guess_rgb;
    logic [NUM_LEDS*COLOR_W-1:0] history_rgb;
    logic                        flash_start;
    logic [COLOR_W-1:0]          flash_rgb;
    logic [PWM_W-1:0]            brightness;
    logic [NUM_LEDS*COLOR_W-1:0] rgb_out;
    logic                        flash_busy;
    logic                        flash_done;

    int n_checks = 0;
    int n_fail   = 0;

    led_array_driver #(
        .NUM_LEDS     (NUM_LEDS),
        .COLOR_W      (COLOR_W),
        .BLINK_DIV    (4),
        .FLASH_CYCLES (2),
        .PWM_W        (PWM_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_guess  (mode_guess),
        .blink_idx   (blink_idx),
        .guess_rgb   (guess_rgb),
        .history_rgb (history_rgb),
        .flash_start (flash_start),
        .flash_rgb   (flash_rgb),
        .brightness  (brightness),
        .rgb_out     (rgb_out),
        .flash_busy  (flash_busy),
        .flash_done  (flash_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int done_cnt;
        int hi_cnt;
        logic [11:0] exp_rgb;

        rst         = 1'b1;
        mode_guess  = 1'b0;
        blink_idx   = '0;
        guess_rgb   = '0;
        history_rgb = 12'hA5C;
        flash_start = 1'b0;
        flash_rgb   = '0;
        brightness  = 4'hF;

        // Reset held for three edges.
        repeat (3) @(negedge clk);
        chk("reset_rgb", 32'(rgb_out), 32'h0);
        chk("reset_busy", 32'(flash_busy), 32'h0);
        chk("reset_done", 32'(flash_done), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("history_rgb", 32'(rgb_out), 32'hA5C);

        // Guess mode, blink LED2: 4 lit, 4 blank, 4 lit, then blank.
        guess_rgb  = 12'hFFF;
        blink_idx  = 2'd2;
        mode_guess = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            exp_rgb = (((k - 1) / 4) % 2 == 0) ? 12'hFFF : 12'hE3F;
            chk($sformatf("blink2_k%0d", k), 32'(rgb_out), 32'(exp_rgb));
        end

        // LED2 is blanked now; move to LED0 and expect a lit-first restart.
        blink_idx = 2'd0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp_rgb = (k <= 4) ? 12'hFFF : 12'hFF8;
            chk($sformatf("restart0_k%0d", k), 32'(rgb_out), 32'(exp_rgb));
        end

        // Flash sequence with a duplicate request in the middle.
        flash_rgb   = 3'b010;
        flash_start = 1'b1;
        done_cnt    = 0;
        for (int j = 1; j <= 18; j++) begin
            @(negedge clk);
            flash_start = (j == 6);
            if (flash_done) done_cnt++;
            if (j <= 16) begin
                exp_rgb = (((j - 1) / 4) % 2 == 0) ? 12'h492 : 12'h000;
                chk($sformatf("flash_rgb_j%0d", j), 32'(rgb_out), 32'(exp_rgb));
                chk($sformatf("flash_busy_j%0d", j), 32'(flash_busy), 32'h1);
            end else begin
                chk($sformatf("flash_exit_rgb_j%0d", j), 32'(rgb_out), 32'hFFF);
                chk($sformatf("flash_exit_busy_j%0d", j), 32'(flash_busy), 32'h0);
            end
            if (j == 17) chk("flash_done_pulse", 32'(flash_done), 32'h1);
        end
        chk("flash_done_count", 32'(done_cnt), 32'd1);

        // Reset during the sixth cycle of a flash aborts it silently.
        flash_start = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            flash_start = 1'b0;
            chk($sformatf("abort_busy_j%0d", j), 32'(flash_busy), 32'h1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rgb", 32'(rgb_out), 32'h0);
        chk("abort_busy", 32'(flash_busy), 32'h0);
        chk("abort_done", 32'(flash_done), 32'h0);
        rst      = 1'b0;
        done_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (flash_done) done_cnt++;
            if (k == 1) chk("abort_resume_rgb", 32'(rgb_out), 32'hFFF);
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Brightness: history all lit, count high cycles of one bit over a full PWM period.
        mode_guess  = 1'b0;
        history_rgb = 12'hFFF;
`ifdef LED_PWM_EN
        brightness = 4'd4;
        @(negedge clk);
        hi_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (rgb_out[0]) hi_cnt++;
        end
        chk("pwm_b4_high", 32'(hi_cnt), 32'd4);
        brightness = 4'd15;
        hi_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (rgb_out == 12'hFFF) hi_cnt++;
        end
        chk("pwm_b15_high", 32'(hi_cnt), 32'd16);
        brightness = 4'd0;
        hi_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (rgb_out != 12'h000) hi_cnt++;
        end
        chk("pwm_b0_dark", 32'(hi_cnt), 32'd0);
`else
        brightness = 4'd0;
        hi_cnt = 0;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (rgb_out == 12'hFFF) hi_cnt++;
        end
        chk("nopwm_full_on", 32'(hi_cnt), 32'd16);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
